presc_updown_counter: RTL
=========================

// Module: presc_updown_counter
// PURPOSE
//  Next-generation modulo counter for display/timing chains. Prescaler, up/down
//  counting, parallel load and separate carry/borrow pulses are built in. The
//  prescaler replaces the external clock-divider-plus-negedge scheme, so the
//  whole block is single-clock and fully synchronous. Instances cascade by
//  feeding carry/borrow of stage N into enable of stage N+1 with DURATION 0.
// PARAMETERS
//  WIDTH       32  width of number, sup and load_value
//  PRESC_WIDTH 32  width of duration and of the internal prescaler count
// PORTS
//  clk         in   1            system clock; everything is registered on posedge
//  reset       in   1            synchronous, active-high; sampled on posedge clk
//  enable      in   1            1: prescaler runs and counting allowed; 0: freeze
//  up_down     in   1            1: count up; 0: count down
//  load        in   1            parallel load request, one-cycle strobe or held
//  load_value  in   WIDTH        value to load; clamped to sup
//  sup         in   WIDTH        terminal (maximum) count; sequence is 0..sup
//  duration    in   PRESC_WIDTH  step every duration+1 clk cycles (0 = every cycle)
//  number      out  WIDTH        current count (registered)
//  carry       out  1            one-cycle pulse: up-count wrapped sup->0
//  borrow      out  1            one-cycle pulse: down-count wrapped 0->sup
//  tick        out  1            one-cycle pulse: a count step occurred this cycle
// BEHAVIOUR
//  Reset
//  - reset=1 at posedge: number=0, carry=0, borrow=0, tick=0, prescaler=0.
//  - reset has priority over everything. Mid-count reset takes effect at that edge.
//  Prescaler (presc, PRESC_WIDTH bits)
//  - Advances only when enable=1.
//  - step = enable && (presc >= duration). On step, presc<=0; else presc<=presc+1.
//  - The >= comparison covers duration lowered below presc: the next enabled
//    cycle steps immediately.
//  - enable=0: presc holds, no step, tick/carry/borrow = 0.
//  Counter update priority per posedge: reset > load > step > hold.
//  - load=1: number <= min(load_value, sup), presc <= 0.
//    carry, borrow and tick are 0 that cycle. Load ignores enable.
//  - step && up_down=1:
//    - number >= sup: number<=0, carry<=1.
//    - else number+1, carry<=0.
//  - step && up_down=0:
//    - number==0: number<=sup, borrow<=1.
//    - number>sup: number<=sup, no borrow.
//    - else number-1.
//  - tick<=step. Outputs are registered: carry/borrow/tick rise in the same
//    cycle number shows the new value, and last exactly one clk cycle.
//  - No step: number holds; carry=borrow=tick=0.
//  Arithmetic and boundaries
//  - Unsigned, WIDTH bits, no overflow past sup.
//  - sup=0: number stays 0. Every up step pulses carry; every down step
//    pulses borrow.
//  - sup changed below number: the next up step wraps to 0 with carry; the
//    next down step goes to sup without borrow.
//  - up_down change takes effect on the next step; no glitch pulses.
//  - Throughput: one step per duration+1 enabled cycles; latency step->number
//    is 1 clk.
// TESTING
//  - Reset: run to number=5, assert reset 1 cycle -> next edge number=0,
//    carry/borrow/tick=0, and next step after exactly duration+1 enabled cycles.
//  - Up wrap: sup=9, duration=3, up -> number increments every 4 clks;
//    9->0 with carry high 1 clk; 10 steps per carry.
//  - Down wrap: sup=9, duration=0, down from 2 -> 1,0,9 on consecutive clks;
//    borrow high only on the cycle number=9.
//  - Load: load_value=7, sup=9 -> number=7 next clk, no pulses, presc cleared;
//    load_value=15 -> number=9 (clamped).
//  - Enable/cascade: two instances (sup=9, duration=0), stage 2 enable = stage 1
//    carry -> stage 2 increments once per 10 clks; enable=0 freezes both.
//  - Live limits: at number=8 set sup=5 -> next up step 0 with carry; at presc=6
//    set duration=2 -> step on next enabled clk.

Source files
------------

// File: rtl/presc_updown_counter.sv
// ============================================================================
// Module   : presc_updown_counter
// Purpose  : Single-clock modulo 0..sup up/down counter with prescaler, load,
//            and carry/borrow/tick pulses for cascaded display/timing chains.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module presc_updown_counter #(
  parameter int WIDTH       = 32,
  parameter int PRESC_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   up_down,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_value,
  input  logic [WIDTH-1:0]       sup,
  input  logic [PRESC_WIDTH-1:0] duration,
  output logic [WIDTH-1:0]       number,
  output logic                   carry,
  output logic                   borrow,
  output logic                   tick
);

  localparam logic [PRESC_WIDTH-1:0] c_PRESC_ONE = PRESC_WIDTH'(1);
  localparam logic [WIDTH-1:0]       c_NUM_ONE   = WIDTH'(1);

  logic [PRESC_WIDTH-1:0] r_presc;
  logic                   w_step;
  logic [WIDTH-1:0]       w_load_clamped;

  // >= rather than == so a duration lowered below r_presc steps at once
  assign w_step         = enable && (r_presc >= duration);
  assign w_load_clamped = (load_value > sup) ? sup : load_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      number  <= '0;
      carry   <= 1'b0;
      borrow  <= 1'b0;
      tick    <= 1'b0;
      r_presc <= '0;
    end else if (load) begin
      number  <= w_load_clamped;
      carry   <= 1'b0;
      borrow  <= 1'b0;
      tick    <= 1'b0;
      r_presc <= '0;
    end else begin
      carry  <= 1'b0;
      borrow <= 1'b0;
      tick   <= w_step;
      if (enable) begin
        r_presc <= w_step ? '0 : (r_presc + c_PRESC_ONE);
      end
      if (w_step) begin
        if (up_down) begin
          if (number >= sup) begin
            number <= '0;
            carry  <= 1'b1;
          end else begin
            number <= number + c_NUM_ONE;
          end
        end else begin
          if (number == '0) begin
            number <= sup;
            borrow <= 1'b1;
          end else if (number > sup) begin
            // Out-of-range count after sup was lowered: snap to sup silently
            number <= sup;
          end else begin
            number <= number - c_NUM_ONE;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
